pipe_mult: RTL and testbench

Fully pipelined, parametrised integer multiplier that replaces the iterative `mult` unit. It accepts a new operand pair every cycle, supports signed and unsigned modes, returns the full 2*WIDTH product, and carries a tag alongside each operation. It sits in the execute stage as the multiply functional unit, and a global `stall` freezes it in place.

---
 rtl/pipe_mult.sv | 93 +++++++++
 tb/tb_pipe_mult.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mult.sv
// Fully pipelined signed/unsigned multiplier: one B-bit multiplier slice is
// consumed per stage, the last stage's registers are the result outputs.
module pipe_mult #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 8,
    parameter int TAG_W  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    input  logic [TAG_W-1:0]   tag_in,
    output logic [WIDTH-1:0]   product,
    output logic [WIDTH-1:0]   product_hi,
    output logic               done,
    output logic [TAG_W-1:0]   tag_out
);

    localparam int P = 2 * WIDTH;
    localparam int B = P / STAGES;

    if (STAGES < 1 || STAGES > P || (P % STAGES) != 0) begin : g_bad_params
        $error("pipe_mult: STAGES must divide 2*WIDTH");
    end

    logic [P-1:0] mc_ext;
    logic [P-1:0] mp_ext;

    always_comb begin
        mc_ext = is_signed ? {{WIDTH{mcand[WIDTH-1]}}, mcand}   : {{WIDTH{1'b0}}, mcand};
        mp_ext = is_signed ? {{WIDTH{mplier[WIDTH-1]}}, mplier} : {{WIDTH{1'b0}}, mplier};
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_q;
        logic [TAG_W-1:0] tag_q;
        logic [P-1:0]     sum_q;
        logic [P-1:0]     mc_q;
        logic [P-1:0]     rem_q;

        logic             src_v;
        logic [TAG_W-1:0] src_tag;
        logic [P-1:0]     src_sum;
        logic [P-1:0]     src_mc;
        logic [P-1:0]     src_rem;
        logic [P-1:0]     pp;

        if (k == 0) begin : g_first
            assign src_v   = start;
            assign src_tag = tag_in;
            assign src_sum = '0;
            assign src_mc  = mc_ext;
            assign src_rem = mp_ext;
        end else begin : g_next
            assign src_v   = g_stage[k-1].v_q;
            assign src_tag = g_stage[k-1].tag_q;
            assign src_sum = g_stage[k-1].sum_q;
            assign src_mc  = g_stage[k-1].mc_q;
            assign src_rem = g_stage[k-1].rem_q;
        end

        // rem always holds the not-yet-consumed multiplier bits at its LSBs
        assign pp = (src_mc * P'(src_rem[B-1:0])) << (k * B);

        always_ff @(posedge clock) begin
            if (!reset) begin
                v_q   <= 1'b0;
                tag_q <= '0;
                sum_q <= '0;
                mc_q  <= '0;
                rem_q <= '0;
            end else if (!stall) begin
                v_q <= src_v;
                // the last stage doubles as the output register: only a retiring op may update it
                if (k != STAGES - 1 || src_v) begin
                    tag_q <= src_tag;
                    sum_q <= src_sum + pp;
                    mc_q  <= src_mc;
                    rem_q <= src_rem >> B;
                end
            end
        end
    end

    assign done       = g_stage[STAGES-1].v_q;
    assign tag_out    = g_stage[STAGES-1].tag_q;
    assign product    = g_stage[STAGES-1].sum_q[WIDTH-1:0];
    assign product_hi = g_stage[STAGES-1].sum_q[P-1:WIDTH];

endmodule

// File: tb/tb_pipe_mult.sv
// Directed and randomised checks of pipe_mult (64x64, 8 stages) with an
// in-order scoreboard fed by a 128-bit reference multiply.
module tb_pipe_mult;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic        is_signed;
    logic [63:0] mcand;
    logic [63:0] mplier;
    logic [3:0]  tag_in;
    logic [63:0] product;
    logic [63:0] product_hi;
    logic        done;
    logic [3:0]  tag_out;

    pipe_mult #(.WIDTH(64), .STAGES(8), .TAG_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .is_signed  (is_signed),
        .mcand      (mcand),
        .mplier     (mplier),
        .tag_in     (tag_in),
        .product    (product),
        .product_hi (product_hi),
        .done       (done),
        .tag_out    (tag_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [127:0] p;
        logic [3:0]   t;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   accepts    = 0;
    int   retires    = 0;
    logic edge_stall;
    logic edge_rst;

    function automatic logic [127:0] ref_mul(input logic s, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea;
        logic [127:0] eb;
        ea = s ? {{64{a[63]}}, a} : {64'b0, a};
        eb = s ? {{64{b[63]}}, b} : {64'b0, b};
        return ea * eb;
    endfunction

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock: model the issue at the edge, then score any retirement at the falling edge.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        edge_stall = stall;
        edge_rst   = reset;
        if (!reset) begin
            exp_q.delete();
        end else if (start && !stall) begin
            exp_q.push_back({ref_mul(is_signed, mcand, mplier), tag_in});
            accepts++;
        end
        @(negedge clock);
        if (edge_rst && !edge_stall && done) begin
            retires++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_product", {product_hi, product}, e.p);
                check("sb_tag", tag_out, e.t);
            end
        end
    endtask

    task automatic issue_and_wait(input logic s, input logic [63:0] a, input logic [63:0] b,
                                  input logic [3:0] t, input int limit, output int n);
        start = 1'b1; is_signed = s; mcand = a; mplier = b; tag_in = t;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < limit) begin
            tick();
            n++;
        end
    endtask

    int n;
    int cnt;
    int acc0;
    int ret0;
    int accepted;

    initial begin
        reset = 1'b0; start = 1'b0; stall = 1'b0; is_signed = 1'b0;
        mcand = '0; mplier = '0; tag_in = '0;

        // reset held for three cycles
        repeat (3) tick();
        check("rst_done", done, 0);
        check("rst_product", {product_hi, product}, 0);
        check("rst_tag", tag_out, 0);
        reset = 1'b1;
        tick();

        // basic unsigned
        issue_and_wait(1'b0, 64'd2, 64'd3, 4'd5, 20, n);
        check("basic_latency", n, 8);
        check("basic_product", product, 6);
        check("basic_hi", product_hi, 0);
        check("basic_tag", tag_out, 5);
        tick();
        check("basic_done_pulse", done, 0);

        // sign mode
        issue_and_wait(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 4'd6, 20, n);
        check("uns_latency", n, 8);
        check("uns_product", product, 64'hFFFF_FFFF_FFFF_FFFD);
        check("uns_hi", product_hi, 2);
        tick();
        issue_and_wait(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 4'd7, 20, n);
        check("sgn_latency", n, 8);
        check("sgn_product", product, 64'hFFFF_FFFF_FFFF_FFFD);
        check("sgn_hi", product_hi, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // back-to-back
        start = 1'b1; is_signed = 1'b1; mcand = 64'hFFFF_FFFF_FFFF_FFEC; mplier = 64'd5; tag_in = 4'd1;
        tick();
        mcand = 64'd7; mplier = 64'd9; tag_in = 4'd2;
        tick();
        mcand = 64'd0; mplier = 64'h1234; tag_in = 4'd3;
        tick();
        start = 1'b0;
        for (int i = 4; i <= 7; i++) tick();
        check("b2b_early", done, 0);
        tick();
        check("b2b_done1", done, 1);
        check("b2b_p1", {product_hi, product}, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF9C});
        check("b2b_t1", tag_out, 1);
        tick();
        check("b2b_done2", done, 1);
        check("b2b_p2", {product_hi, product}, 63);
        check("b2b_t2", tag_out, 2);
        tick();
        check("b2b_done3", done, 1);
        check("b2b_p3", {product_hi, product}, 0);
        check("b2b_t3", tag_out, 3);
        tick();
        check("b2b_end", done, 0);

        // stall: op issued at n=1, stall on n=5..7, ignored start at n=6
        n = 0;
        for (int i = 1; i <= 11; i++) begin
            stall = (i >= 5 && i <= 7);
            start = (i == 1 || i == 6);
            is_signed = 1'b0;
            mcand  = (i == 1) ? 64'h10 : 64'd3;
            mplier = (i == 1) ? 64'h10 : 64'd3;
            tag_in = (i == 1) ? 4'd4 : 4'd9;
            tick();
            if (done && n == 0) n = i;
        end
        start = 1'b0; stall = 1'b0;
        check("stall_latency", n, 11);
        check("stall_product", {product_hi, product}, 64'h100);
        check("stall_tag", tag_out, 4);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) cnt++;
        end
        check("stall_no_ghost", cnt, 0);

        // reset mid-flight
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; is_signed = 1'b0; mcand = 64'(i + 1); mplier = 64'd11; tag_in = 4'(i + 8);
            tick();
        end
        start = 1'b1; reset = 1'b0;
        tick();
        start = 1'b0; reset = 1'b1;
        check("mid_rst_product", {product_hi, product}, 0);
        check("mid_rst_tag", tag_out, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) cnt++;
        end
        check("mid_rst_no_done", cnt, 0);
        check("mid_rst_idle", {product_hi, product}, 0);
        issue_and_wait(1'b1, 64'd12, 64'hFFFF_FFFF_FFFF_FFFE, 4'd10, 20, n);
        check("post_rst_latency", n, 8);
        check("post_rst_product", {product_hi, product}, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFE8});
        tick();

        // random traffic with stalls
        acc0 = accepts;
        ret0 = retires;
        accepted = 0;
        while (accepted < 1000) begin
            stall     = ($urandom_range(0, 4) == 0);
            start     = ($urandom_range(0, 3) != 0);
            is_signed = $urandom_range(0, 1) == 1;
            mcand     = {$urandom(), $urandom()};
            mplier    = {$urandom(), $urandom()};
            tag_in    = 4'($urandom());
            if (start && !stall) accepted++;
            tick();
        end
        start = 1'b0; stall = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check("rand_drained", exp_q.size(), 0);
        check("rand_accepts", accepts - acc0, 1000);
        check("rand_retires", retires - ret0, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
